// File: rtl/notas_pkg.sv
// ============================================================================
// notas_pkg : shared FSM state encoding, note codes and debounce default
// Revision  : 1.0
// ============================================================================
`default_nettype none

package notas_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    DEB_PRESS = 3'd1,
    LOAD      = 3'd2,
    STROBE    = 3'd3,
    WAIT_REL  = 3'd4,
    DEB_REL   = 3'd5,
    LOCKED    = 3'd6
  } estado_t;

  localparam logic [3:0] LA_BAIXO = 4'b1110;
  localparam logic [3:0] SI_BAIXO = 4'b1111;
  localparam logic [3:0] DO_ALTO  = 4'b0001;
  localparam logic [3:0] RE_ALTO  = 4'b0010;
  localparam logic [3:0] INVAL1   = 4'b0000;
  localparam logic [3:0] INVAL2   = 4'b1000;

  localparam int DEBOUNCE_DEFAULT = 16;

endpackage

`default_nettype wire

// File: rtl/sincronizador.sv
// ============================================================================
// sincronizador : parameterized-width two-flop synchronizer, async active-low reset
// Revision      : 1.0
// ============================================================================
`default_nettype none

module sincronizador #(
  parameter int WIDTH = 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] meta_q;
  logic [WIDTH-1:0] sync_q;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

`default_nettype wire

// File: rtl/captura_notas.sv
// ============================================================================
// captura_notas : synchronize/debounce note button, latch note, count, lock on fim
// Optional note history shift register enabled by `define CAPTURA_HISTORICO_EN
// Revision      : 1.0
// ============================================================================
`default_nettype none

module captura_notas
  import notas_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        botao,
  input  logic [3:0]  nota_sw,
  input  logic        fim,
  output logic        ok,
  output logic [3:0]  nota_out,
  output logic [2:0]  conta,
  output logic        travado,
  output logic [19:0] historico
);

  localparam logic [7:0] DEB_LAST = 8'(DEBOUNCE_CYCLES - 1);

  logic       bt_s;
  logic [3:0] nt_s;

  sincronizador #(.WIDTH(1)) u_sinc_botao (
    .clock (clock),
    .reset (reset),
    .d_i   (botao),
    .q_o   (bt_s)
  );

  sincronizador #(.WIDTH(4)) u_sinc_nota (
    .clock (clock),
    .reset (reset),
    .d_i   (nota_sw),
    .q_o   (nt_s)
  );

  estado_t    state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic       ok_q, ok_d;
  logic [3:0] nota_q, nota_d;
  logic [2:0] conta_q, conta_d;
  logic       trav_q, trav_d;
  logic [1:0] fill_q;
  logic       armed_q;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      ok_q    <= 1'b0;
      nota_q  <= '0;
      conta_q <= '0;
      trav_q  <= 1'b0;
      fill_q  <= '0;
      armed_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ok_q    <= ok_d;
      nota_q  <= nota_d;
      conta_q <= conta_d;
      trav_q  <= trav_d;
      // bt_s only reflects the real button once the synchronizer has refilled;
      // a button held through reset must be seen released before it can arm.
      if (fill_q != 2'd2) fill_q <= fill_q + 2'd1;
      armed_q <= armed_q | ((fill_q == 2'd2) & ~bt_s);
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ok_d    = 1'b0;
    nota_d  = nota_q;
    conta_d = conta_q;
    trav_d  = trav_q;
    case (state_q)
      IDLE: begin
        if (fim) begin
          state_d = LOCKED;
          trav_d  = 1'b1;
        end else if (bt_s && armed_q) begin
          state_d = DEB_PRESS;
          cnt_d   = '0;
        end
      end
      DEB_PRESS: begin
        if (!bt_s) begin
          state_d = IDLE;
        end else if (cnt_q == DEB_LAST) begin
          // note is captured on the edge entering LOAD so it leads ok by a cycle
          state_d = LOAD;
          nota_d  = nt_s;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      LOAD: begin
        state_d = STROBE;
        ok_d    = 1'b1;
        if (conta_q != 3'd7) conta_d = conta_q + 3'd1;
      end
      STROBE: state_d = WAIT_REL;
      WAIT_REL: begin
        if (!bt_s) begin
          state_d = DEB_REL;
          cnt_d   = '0;
        end
      end
      DEB_REL: begin
        if (bt_s) begin
          state_d = WAIT_REL;
        end else if (cnt_q == DEB_LAST) begin
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      LOCKED:  trav_d = 1'b1;
      default: state_d = IDLE;
    endcase
  end

  assign ok       = ok_q;
  assign nota_out = nota_q;
  assign conta    = conta_q;
  assign travado  = trav_q;

`ifdef CAPTURA_HISTORICO_EN
  logic [19:0] hist_q;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      hist_q <= '0;
    end else if (state_q == DEB_PRESS && state_d == LOAD) begin
      hist_q <= {hist_q[15:0], nt_s};
    end
  end

  assign historico = hist_q;
`else
  assign historico = '0;
`endif

endmodule

`default_nettype wire

// File: doc/captura_notas.md
# captura_notas

Input-conditioning stage directly upstream of the word-classifier FSM. It synchronizes and debounces the raw note-entry push-button and latches the 4-bit note switches. Each accepted press produces exactly one clean `ok` strobe, with `nota_out` already stable. It also counts entered notes and stops accepting input once the downstream classifier raises `fim`.

## Interface
- `DEBOUNCE_CYCLES`, default 16: consecutive stable cycles needed to accept a press or a release; legal range 2..255.
- `clock`, in, 1: single system clock, rising-edge.
- `reset`, in, 1: asynchronous, active-low reset.
- `botao`, in, 1: raw push-button, asynchronous, bouncy.
- `nota_sw`, in, 4: raw note switches, asynchronous.
- `fim`, in, 1: end flag from the downstream classifier, synchronous to `clock`.
- `ok`, out, 1: one-cycle strobe, one per accepted press.
- `nota_out`, out, 4: latched note; held until the next accepted press.
- `conta`, out, 3: number of notes delivered; saturates at 7.
- `travado`, out, 1: high once input is locked by `fim`.
- `historico`, out, 20: last five notes, newest in [3:0] (see Configuration).

## Operation
- `botao` and `nota_sw` each pass through a 2-FF synchronizer before any use (`bt_s`, `nt_s`).
- Note codes are passed through unfiltered. 0000 and 1000 are delivered like any other note; the downstream stage treats them as terminators.
- FSM states: IDLE, DEB_PRESS, LOAD, STROBE, WAIT_REL, DEB_REL, LOCKED.
- IDLE:
  - `fim`=1 → LOCKED.
  - else `bt_s`=1 → DEB_PRESS, debounce counter cleared.
- DEB_PRESS:
  - `bt_s`=0 → IDLE (bounce rejected).
  - else the counter increments; on the edge where counter == `DEBOUNCE_CYCLES`-1 with `bt_s`=1 → LOAD.
- LOAD: `nota_out` <= `nt_s`; next edge → STROBE.
- STROBE:
  - `ok`=1 for this single cycle.
  - `conta` increments, saturating at 7.
  - Next edge → WAIT_REL.
- WAIT_REL: `bt_s`=0 → DEB_REL, counter cleared.
- DEB_REL:
  - `bt_s`=1 → WAIT_REL (release bounce rejected; never a second strobe).
  - `DEBOUNCE_CYCLES` consecutive low cycles → IDLE.
- LOCKED: absorbing state until reset; `travado`=1; `botao` ignored.
- `fim` is sampled only in IDLE. A press already in progress completes its strobe first.
- Reset mid-operation: all registers clear immediately; a held button must be released and pressed again after reset deasserts.

## Timing
- Reset values: `ok`=0, `nota_out`=0000, `conta`=000, `travado`=0, `historico`=0, state IDLE, synchronizers 0.
- All outputs are registered; no combinational input→output path.
- Latency: if `botao` is first sampled high at edge r and stays stable, `ok` is high in the cycle after edge r+`DEBOUNCE_CYCLES`+3.
- `nota_out` updates exactly one cycle before `ok` rises. It is stable during the whole `ok` cycle and until the next LOAD.
- `ok` is never asserted in two consecutive cycles. Minimum spacing between strobes is 2·`DEBOUNCE_CYCLES`+4 cycles.
- `nota_sw` must be stable for the debounce window. The value sampled in LOAD is the one delivered.

## Configuration
- `CAPTURA_HISTORICO_EN`:
  - Defined: a 20-bit shift register updates on each LOAD. `historico` <= {`historico`[15:0], `nt_s`}, so `historico` mirrors the new `nota_out` from the same edge. It clears on reset.
  - Undefined: `historico` is tied to 0 and no shift register is built. The port is always present.

## Structure
- Shared package `notas_pkg`:
  - state encoding constants;
  - note constants (`LA_BAIXO`=1110, `SI_BAIXO`=1111, `DO_ALTO`=0001, `RE_ALTO`=0010, `INVAL1`=0000, `INVAL2`=1000);
  - default `DEBOUNCE_CYCLES`.
- Sub-module `sincronizador` (parameterized-width 2-FF synchronizer), instantiated for `botao` and for `nota_sw`.
- Debounce counter and FSM live in `captura_notas` itself.

## Test plan
- `DEBOUNCE_CYCLES`=4, `nota_sw`=1110, `botao` high from edge 10 for 20 cycles → single `ok` pulse in the cycle after edge 17; `nota_out`=1110 from the cycle after edge 16; `conta`=1.
- Press bounce: `botao` high 2 cycles, low 1, then high 20 → one `ok`, with latency measured from the final rise.
- Release bounce: after a strobe, `botao` low 2, high 1, low 20 → no second `ok`; FSM back in IDLE.
- Nine clean presses with notes 0001..1001 → nine `ok` pulses; `conta` saturates at 7; `nota_out`=1001.
- `fim`=1 while idle, then press → no `ok`, `travado`=1; pulse `reset` low → `travado`=0 and presses are accepted again.
- With `CAPTURA_HISTORICO_EN`, notes 0001, 0010, 1110 → `historico`=20'h0012E; without the macro → `historico`=0.
